// File: rtl/mem_stage.sv
// Purpose : ex/mem pipeline register plus load/store sequencer towards the memory controller.
// Latency : non-mem op visible on wd_o/wreg_o/wdata_o one edge after acceptance; mem op >= 3 cycles (accept, BUSY, done).
// Backpress: stall_req_o holds upstream while an access is outstanding; rdy=0 freezes every register.
//
// Ports: clk/rst (async active-low), rdy (global hold); ex-side wd_i/wreg_i/wdata_i/aluop_i/
//        mem_addr_i/load_status_i; controller side mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o/
//        mem_len_o with mem_done_i/mem_rdata_i; write-back side wd_o/wreg_o/wdata_o; stall_req_o;
//        misalign_o.
// Optional feature: define MEM_ALIGN_CHECK_EN to suppress misaligned half/word accesses and raise
//        the sticky misalign_o flag; otherwise every access issues and misalign_o stays 0.
// aluop encoding (8 bits): LB 0x20, LH 0x21, LW 0x22, LBU 0x23, LHU 0x24, SB 0x28, SH 0x29, SW 0x2A;
//        any other value is a non-memory op that passes straight through.

module mem_stage #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic [4:0]        wd_i,
    input  logic              wreg_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [7:0]        aluop_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic              load_status_i,
    output logic              stall_req_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [1:0]        mem_len_o,
    input  logic              mem_done_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              misalign_o
);

    localparam logic [7:0] EX_LB  = 8'h20;
    localparam logic [7:0] EX_LH  = 8'h21;
    localparam logic [7:0] EX_LW  = 8'h22;
    localparam logic [7:0] EX_LBU = 8'h23;
    localparam logic [7:0] EX_LHU = 8'h24;
    localparam logic [7:0] EX_SB  = 8'h28;
    localparam logic [7:0] EX_SH  = 8'h29;
    localparam logic [7:0] EX_SW  = 8'h2A;

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_BUSY = 1'b1} state_e;

    state_e state_q, state_d;

    // Op register (ex/mem boundary)
    logic              op_v_q, op_v_d;
    logic [4:0]        wd_q, wd_d;
    logic              wreg_q, wreg_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [7:0]        aluop_q, aluop_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              ld_q, ld_d;

    // Write-back output register
    logic [4:0]        wd_out_q, wd_out_d;
    logic              wreg_out_q, wreg_out_d;
    logic [DATA_W-1:0] wdata_out_q, wdata_out_d;
    logic              misalign_q, misalign_d;

    // Decode of the held op
    logic              is_mem;
    logic [1:0]        len;
    logic              misaligned;
    logic              mem_go;
    logic              accept;
    logic [DATA_W-1:0] load_data;

    always_comb begin
        is_mem = 1'b0;
        len    = 2'd0;
        case (aluop_q)
            EX_LB, EX_LBU, EX_SB: begin is_mem = 1'b1; len = 2'd0; end
            EX_LH, EX_LHU, EX_SH: begin is_mem = 1'b1; len = 2'd1; end
            EX_LW, EX_SW:         begin is_mem = 1'b1; len = 2'd2; end
            default:              begin is_mem = 1'b0; len = 2'd0; end
        endcase
    end

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = ((len == 2'd1) && addr_q[0]) || ((len == 2'd2) && (addr_q[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    // A misaligned op (when checking is built in) is retired in IDLE and never stalls.
    assign mem_go      = op_v_q && is_mem && !misaligned;
    // Stall drops in the done cycle so the next op is latched on the same edge as the result.
    assign stall_req_o = mem_go && !((state_q == S_BUSY) && mem_done_i);
    assign accept      = rdy && !stall_req_o;

    always_comb begin
        case (aluop_q)
            EX_LB:   load_data = {{(DATA_W-8){mem_rdata_i[7]}}, mem_rdata_i[7:0]};
            EX_LBU:  load_data = {{(DATA_W-8){1'b0}}, mem_rdata_i[7:0]};
            EX_LH:   load_data = {{(DATA_W-16){mem_rdata_i[15]}}, mem_rdata_i[15:0]};
            EX_LHU:  load_data = {{(DATA_W-16){1'b0}}, mem_rdata_i[15:0]};
            default: load_data = mem_rdata_i;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; done pulses while rdy=0 are deliberately dropped.
    always_comb begin
        state_d = state_q;
        if (rdy) begin
            case (state_q)
                S_IDLE:  if (mem_go) state_d = S_BUSY;
                S_BUSY:  if (mem_done_i) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Controller-facing outputs are only live in BUSY.
    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_len_o   = 2'd0;
        if (state_q == S_BUSY) begin
            mem_req_o   = 1'b1;
            mem_we_o    = !ld_q;
            mem_addr_o  = addr_q;
            mem_wdata_o = wdata_q;
            mem_len_o   = len;
        end
    end

    // Op register next value
    always_comb begin
        op_v_d  = op_v_q;
        wd_d    = wd_q;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        aluop_d = aluop_q;
        addr_d  = addr_q;
        ld_d    = ld_q;
        if (accept) begin
            op_v_d  = 1'b1;
            wd_d    = wd_i;
            wreg_d  = wreg_i;
            wdata_d = wdata_i;
            aluop_d = aluop_i;
            addr_d  = mem_addr_i;
            ld_d    = load_status_i;
        end
    end

    // Write-back register next value
    always_comb begin
        wd_out_d    = wd_out_q;
        wreg_out_d  = wreg_out_q;
        wdata_out_d = wdata_out_q;
        misalign_d  = misalign_q;
        if (rdy) begin
            case (state_q)
                S_IDLE: begin
                    if (op_v_q && is_mem) begin
                        // Bubble while the access runs (or for a suppressed misaligned access).
                        wd_out_d    = '0;
                        wreg_out_d  = 1'b0;
                        wdata_out_d = '0;
                        if (misaligned) misalign_d = 1'b1;
                    end else begin
                        wd_out_d    = wd_q;
                        wreg_out_d  = op_v_q && wreg_q && (wd_q != 5'd0);
                        wdata_out_d = wdata_q;
                    end
                end
                S_BUSY: begin
                    if (mem_done_i) begin
                        wd_out_d = wd_q;
                        if (ld_q) begin
                            // Loads to x0 were still issued for side effects; only the write is dropped.
                            wreg_out_d  = (wd_q != 5'd0);
                            wdata_out_d = load_data;
                        end else begin
                            wreg_out_d  = 1'b0;
                            wdata_out_d = '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_v_q      <= 1'b0;
            wd_q        <= '0;
            wreg_q      <= 1'b0;
            wdata_q     <= '0;
            aluop_q     <= '0;
            addr_q      <= '0;
            ld_q        <= 1'b0;
            wd_out_q    <= '0;
            wreg_out_q  <= 1'b0;
            wdata_out_q <= '0;
            misalign_q  <= 1'b0;
        end else begin
            op_v_q      <= op_v_d;
            wd_q        <= wd_d;
            wreg_q      <= wreg_d;
            wdata_q     <= wdata_d;
            aluop_q     <= aluop_d;
            addr_q      <= addr_d;
            ld_q        <= ld_d;
            wd_out_q    <= wd_out_d;
            wreg_out_q  <= wreg_out_d;
            wdata_out_q <= wdata_out_d;
            misalign_q  <= misalign_d;
        end
    end

    assign wd_o       = wd_out_q;
    assign wreg_o     = wreg_out_q;
    assign wdata_o    = wdata_out_q;
    assign misalign_o = misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
// Purpose : directed self-checking bench for mem_stage (pass-through, loads, stores, stalls, reset).
// Latency : inputs driven and outputs sampled on the falling clock edge, away from the active edge.
// Backpress: the bench plays the memory controller, pulsing mem_done_i after a chosen BUSY delay.

module tb_mem_stage;

    localparam logic [7:0] EX_NOP = 8'h00;
    localparam logic [7:0] EX_ADD = 8'h01;
    localparam logic [7:0] EX_LB  = 8'h20;
    localparam logic [7:0] EX_LH  = 8'h21;
    localparam logic [7:0] EX_LW  = 8'h22;
    localparam logic [7:0] EX_LBU = 8'h23;
    localparam logic [7:0] EX_SH  = 8'h29;
    localparam logic [7:0] EX_SW  = 8'h2A;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i;
    logic [7:0]  aluop_i;
    logic [31:0] mem_addr_i;
    logic        load_status_i;
    logic        stall_req_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [1:0]  mem_len_o;
    logic        mem_done_i;
    logic [31:0] mem_rdata_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        misalign_o;

    int n_cmp = 0;
    int n_err = 0;
    int sc;
    int rl;

    mem_stage #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .wd_i          (wd_i),
        .wreg_i        (wreg_i),
        .wdata_i       (wdata_i),
        .aluop_i       (aluop_i),
        .mem_addr_i    (mem_addr_i),
        .load_status_i (load_status_i),
        .stall_req_o   (stall_req_o),
        .mem_req_o     (mem_req_o),
        .mem_we_o      (mem_we_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_len_o     (mem_len_o),
        .mem_done_i    (mem_done_i),
        .mem_rdata_i   (mem_rdata_i),
        .wd_o          (wd_o),
        .wreg_o        (wreg_o),
        .wdata_o       (wdata_o),
        .misalign_o    (misalign_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete (observed timeout, required finish)");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [7:0] op, input logic [4:0] wd, input logic wreg,
                         input logic [31:0] wdata, input logic [31:0] addr, input logic ld);
        aluop_i       = op;
        wd_i          = wd;
        wreg_i        = wreg;
        wdata_i       = wdata;
        mem_addr_i    = addr;
        load_status_i = ld;
    endtask

    task automatic nop;
        drive(EX_NOP, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    // Present an op, let it be accepted, then return to a nop; ends in the first cycle after acceptance.
    task automatic issue(input logic [7:0] op, input logic [4:0] wd, input logic wreg,
                         input logic [31:0] wdata, input logic [31:0] addr, input logic ld);
        drive(op, wd, wreg, wdata, addr, ld);
        tick;
        mem_done_i = 1'b0;
        nop;
    endtask

    // From the post-accept IDLE cycle, spend n_pre BUSY cycles without done; ends in the next BUSY cycle.
    task automatic wait_busy(input int n_pre, output int stall_cnt, output int req_low);
        stall_cnt = 0;
        req_low   = 0;
        for (int i = 0; i <= n_pre; i++) begin
            #1;
            if (stall_req_o === 1'b1) stall_cnt++;
            if (mem_req_o === 1'b0) req_low++;
            tick;
        end
    endtask

    task automatic pulse_done(input logic [31:0] d);
        mem_done_i  = 1'b1;
        mem_rdata_i = d;
        #1;
    endtask

    initial begin
        rst         = 1'b0;
        rdy         = 1'b1;
        mem_done_i  = 1'b0;
        mem_rdata_i = 32'h0;
        nop;

        // Reset state
        @(negedge clk);
        chk("rst_wd", wd_o, 0);
        chk("rst_wreg", wreg_o, 0);
        chk("rst_wdata", wdata_o, 0);
        chk("rst_req", mem_req_o, 0);
        chk("rst_stall", stall_req_o, 0);
        chk("rst_misalign", misalign_o, 0);
        rst = 1'b1;

        // Non-mem pass-through: two edges after presenting the op
        issue(EX_ADD, 5'd5, 1'b1, 32'h1234, 32'h0, 1'b0);
        #1 chk("add_stall", stall_req_o, 0);
        tick;
        chk("add_wd", wd_o, 5);
        chk("add_wreg", wreg_o, 1);
        chk("add_wdata", wdata_o, 32'h1234);
        chk("add_stall2", stall_req_o, 0);

        // Write to x0 is suppressed
        issue(EX_ADD, 5'd0, 1'b1, 32'h77, 32'h0, 1'b0);
        tick;
        chk("add_x0_wreg", wreg_o, 0);
        chk("add_x0_wdata", wdata_o, 32'h77);

        // LB, done after 3 BUSY cycles without it
        issue(EX_LB, 5'd7, 1'b1, 32'h0, 32'h100, 1'b1);
        wait_busy(3, sc, rl);
        chk("lb_stall_cycles", sc, 4);
        chk("lb_req_low", rl, 1);
        chk("lb_bubble_wreg", wreg_o, 0);
        pulse_done(32'h0000_00F0);
        chk("lb_req", mem_req_o, 1);
        chk("lb_len", mem_len_o, 0);
        chk("lb_we", mem_we_o, 0);
        chk("lb_addr", mem_addr_o, 32'h100);
        chk("lb_stall_done", stall_req_o, 0);
        tick;
        mem_done_i = 1'b0;
        #1;
        chk("lb_wdata", wdata_o, 32'hFFFF_FFF0);
        chk("lb_wreg", wreg_o, 1);
        chk("lb_wd", wd_o, 7);
        chk("lb_req_after", mem_req_o, 0);

        // LBU zero-extends
        issue(EX_LBU, 5'd7, 1'b1, 32'h0, 32'h100, 1'b1);
        wait_busy(3, sc, rl);
        chk("lbu_stall_cycles", sc, 4);
        pulse_done(32'h0000_00F0);
        tick;
        mem_done_i = 1'b0;
        chk("lbu_wdata", wdata_o, 32'h0000_00F0);

        // SW
        issue(EX_SW, 5'd0, 1'b0, 32'hDEAD_BEEF, 32'h200, 1'b0);
        wait_busy(0, sc, rl);
        chk("sw_stall_cycles", sc, 1);
        pulse_done(32'h0);
        chk("sw_we", mem_we_o, 1);
        chk("sw_len", mem_len_o, 2);
        chk("sw_mwdata", mem_wdata_o, 32'hDEAD_BEEF);
        chk("sw_addr", mem_addr_o, 32'h200);
        tick;
        mem_done_i = 1'b0;
        chk("sw_wreg", wreg_o, 0);
        chk("sw_wdata", wdata_o, 0);

        // LH with rdy=0 during BUSY: done while frozen is ignored
        issue(EX_LH, 5'd3, 1'b1, 32'h0, 32'h104, 1'b1);
        wait_busy(0, sc, rl);
        rdy = 1'b0;
        pulse_done(32'h0000_8001);
        chk("rdy0_req", mem_req_o, 1);
        tick;
        mem_done_i = 1'b0;
        #1;
        chk("rdy0_req_hold", mem_req_o, 1);
        chk("rdy0_wreg", wreg_o, 0);
        rdy = 1'b1;
        #1 chk("rdy1_stall", stall_req_o, 1);
        tick;
        chk("rdy1_req", mem_req_o, 1);
        pulse_done(32'h0000_8001);
        tick;
        mem_done_i = 1'b0;
        chk("lh_wdata", wdata_o, 32'hFFFF_8001);
        chk("lh_wreg", wreg_o, 1);
        chk("lh_wd", wd_o, 3);

        // Back-to-back LW then SH
        issue(EX_LW, 5'd10, 1'b1, 32'h0, 32'h400, 1'b1);
        wait_busy(0, sc, rl);
        pulse_done(32'h1234_5678);
        chk("b2b_lw_req", mem_req_o, 1);
        drive(EX_SH, 5'd0, 1'b0, 32'h0000_CAFE, 32'h402, 1'b0);
        tick;
        mem_done_i = 1'b0;
        nop;
        #1;
        chk("b2b_lw_wdata", wdata_o, 32'h1234_5678);
        chk("b2b_lw_wreg", wreg_o, 1);
        chk("b2b_lw_wd", wd_o, 10);
        chk("b2b_gap_stall", stall_req_o, 1);
        wait_busy(0, sc, rl);
        chk("b2b_req_low_cycles", rl, 1);
        chk("b2b_sh_req", mem_req_o, 1);
        chk("b2b_sh_addr", mem_addr_o, 32'h402);
        chk("b2b_sh_len", mem_len_o, 1);
        chk("b2b_sh_we", mem_we_o, 1);
        chk("b2b_sh_mwdata", mem_wdata_o, 32'h0000_CAFE);
        pulse_done(32'h0);
        tick;
        mem_done_i = 1'b0;
        chk("b2b_sh_wreg", wreg_o, 0);

        // Misaligned word load
`ifdef MEM_ALIGN_CHECK_EN
        issue(EX_LW, 5'd11, 1'b1, 32'h0, 32'h102, 1'b1);
        #1;
        chk("mis_stall", stall_req_o, 0);
        chk("mis_req0", mem_req_o, 0);
        tick;
        chk("mis_req1", mem_req_o, 0);
        chk("mis_flag", misalign_o, 1);
        chk("mis_wreg", wreg_o, 0);
        tick;
        tick;
        chk("mis_flag_sticky", misalign_o, 1);
`else
        issue(EX_LW, 5'd11, 1'b1, 32'h0, 32'h102, 1'b1);
        wait_busy(0, sc, rl);
        chk("mis_req", mem_req_o, 1);
        chk("mis_addr", mem_addr_o, 32'h102);
        chk("mis_flag", misalign_o, 0);
        pulse_done(32'h0000_0055);
        tick;
        mem_done_i = 1'b0;
        chk("mis_wdata", wdata_o, 32'h55);
        chk("mis_flag_after", misalign_o, 0);
`endif

        // Async reset while BUSY
        issue(EX_LW, 5'd9, 1'b1, 32'h0, 32'h300, 1'b1);
        wait_busy(1, sc, rl);
        chk("rstb_req_before", mem_req_o, 1);
        rst = 1'b0;
        #1;
        chk("rstb_req", mem_req_o, 0);
        chk("rstb_stall", stall_req_o, 0);
        tick;
        rst = 1'b1;
        tick;
        pulse_done(32'hAAAA_5555);
        chk("spur_req", mem_req_o, 0);
        chk("spur_stall", stall_req_o, 0);
        tick;
        mem_done_i = 1'b0;
        chk("spur_wreg", wreg_o, 0);
        chk("spur_wdata", wdata_o, 0);
        chk("spur_wd", wd_o, 0);
        chk("spur_misalign", misalign_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Pipeline stage downstream of `ex`: registers `ex` results (ex/mem boundary), performs loads/stores through a request/done handshake to the memory controller, and presents registered write-back results to `mem_wb`. It stalls upstream while a memory access is outstanding.

## Interface
Parameters:
- ADDR_W, 32, memory address width
- DATA_W, 32, data width (fixed at 32 for RV32I)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low (rst=0 resets)
- rdy  in  1  global ready; when 0 all registers hold, no new request issued
- wd_i  in  5  destination register from `ex`
- wreg_i  in  1  write-enable from `ex`
- wdata_i  in  32  ALU result, or store data for stores
- aluop_i  in  `AluOpBus`  op; only `EX_LB/LH/LW/LBU/LHU/SB/SH/SW` are acted on, others are pass-through
- mem_addr_i  in  32  effective address from `ex`
- load_status_i  in  1  1 = load
- stall_req_o  out  1  hold `ex` and earlier stages
- mem_req_o  out  1  access request, held until done
- mem_we_o  out  1  1 = store
- mem_addr_o  out  32  access address
- mem_wdata_o  out  32  store data, LSB-aligned
- mem_len_o  out  2  0 byte, 1 half, 2 word
- mem_done_i  in  1  one-cycle completion pulse
- mem_rdata_i  in  32  load data, valid with mem_done_i, LSB-aligned
- wd_o  out  5  to `mem_wb`/forwarding
- wreg_o  out  1  to `mem_wb`/forwarding
- wdata_o  out  32  to `mem_wb`/forwarding
- misalign_o  out  1  sticky misalignment flag (see Configuration)

## Operation
- Op register (op_v, wd, wreg, wdata, aluop, addr, ld) loads from `ex` on every edge where rdy=1 and stall_req_o=0; op_v=1 on load.
- is_mem = aluop in the load/store set.
- FSM states: IDLE, BUSY.
  - IDLE, op not mem: output regs <= op (wd, wreg && wd!=0, wdata); stays IDLE.
  - IDLE, op is mem: output wreg_o<=0 (bubble); -> BUSY.
  - BUSY: mem_req_o=1, addr/we/len/wdata driven from op register; on mem_done_i: output regs <= result, -> IDLE.
- stall_req_o = op_v && is_mem && !(state==BUSY && mem_done_i) (combinational); the op register reloads on the done edge.
- Load result: LB sext rdata[7:0], LH sext [15:0], LW [31:0], LBU/LHU zext; wreg_o = wd!=0.
- Store: wreg_o=0, wdata_o=0; mem_wdata_o = op wdata unmodified, controller uses mem_len_o.
- Loads to x0 still issue (IO side effects); the result is discarded.
- mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_len_o are 0 outside BUSY.

## Timing
- Reset values: state IDLE, op_v 0, all outputs 0.
- Non-mem op: accepted at edge N, visible on wd/wreg/wdata_o after edge N+1.
- Mem op: accepted at N; N+1 -> BUSY, mem_req_o high from N+1; done at cycle D; result on outputs after edge D; mem_req_o low from D+1. Minimum 3 cycles when done arrives in the first BUSY cycle.
- mem_done_i outside BUSY is ignored.
- rdy=0 during BUSY: mem_req_o stays high; a done pulse arriving while rdy=0 is ignored; the controller must re-pulse after rdy returns.
- Async reset mid-access: mem_req_o drops immediately; the op is lost.
- Back-to-back mem ops: the second is latched on the first's done edge; mem_req_o drops for exactly one cycle between them.

## Configuration
- MEM_ALIGN_CHECK_EN defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, go IDLE->IDLE without issuing; wreg_o=0; misalign_o set to 1 and held until reset; no stall.
- Undefined: accesses issue unchanged regardless of alignment; misalign_o tied 0.

## Test plan
- Reset released, `EX_ADD` wd=5 wdata=0x1234 -> two edges later wd_o=5 wreg_o=1 wdata_o=0x1234; stall_req_o never high.
- `EX_LB` addr 0x100, done after 3 BUSY cycles with rdata=0x000000F0 -> mem_len_o=0, we=0; stall high 4 cycles; wdata_o=0xFFFFFFF0; same with `EX_LBU` -> 0x000000F0.
- `EX_SW` addr 0x200 wdata=0xDEADBEEF -> mem_we_o=1, mem_len_o=2, mem_wdata_o=0xDEADBEEF; wreg_o=0 after done.
- `EX_LW` then `EX_SH` back-to-back -> mem_req_o low for exactly one cycle between; the second op's addr/len appear the next BUSY cycle.
- rst driven low while BUSY -> mem_req_o and stall_req_o 0 asynchronously; after release, a spurious mem_done_i causes no output change.
- With MEM_ALIGN_CHECK_EN: `EX_LW` addr 0x102 -> no mem_req_o, misalign_o=1 persists; without the macro the request issues with mem_addr_o=0x102.
